// File: rtl/vec_add_compute.sv
// vec_add_compute: streams words from an input buffer, adds ADD_VALUE and
// writes them out in bursts. Define VEC_ADD_CYCLE_CNT_EN for the cycles port.
module vec_add_compute #(
  parameter int MEM_LEN_BITS   = 8,
  parameter int MEM_ADDR_BITS  = 64,
  parameter int MEM_DATA_BITS  = 64,
  parameter int HOST_DATA_BITS = 32,
  parameter int MAX_BURST      = 16,
  parameter int ADD_VALUE      = 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      launch,
  output logic                      finish,
  input  logic [HOST_DATA_BITS-1:0] length,
  input  logic [MEM_ADDR_BITS-1:0]  inp_baddr,
  input  logic [MEM_ADDR_BITS-1:0]  out_baddr,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic                      mem_req_opcode,
  output logic [MEM_LEN_BITS-1:0]   mem_req_len,
  output logic [MEM_ADDR_BITS-1:0]  mem_req_addr,
  input  logic                      mem_rd_valid,
  output logic                      mem_rd_ready,
  input  logic [MEM_DATA_BITS-1:0]  mem_rd_bits,
  output logic                      mem_wr_valid,
  input  logic                      mem_wr_ready,
  output logic [MEM_DATA_BITS-1:0]  mem_wr_bits
`ifdef VEC_ADD_CYCLE_CNT_EN
  ,
  output logic [HOST_DATA_BITS-1:0] cycles
`endif
);

  localparam int IW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int BW = $clog2(MAX_BURST) + 1;
  localparam logic [MEM_ADDR_BITS-1:0] STEP =
    MEM_ADDR_BITS'(MEM_DATA_BITS / 8);
  localparam logic [MEM_DATA_BITS-1:0] ADDV =
    MEM_DATA_BITS'(ADD_VALUE);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_DATA, WR_REQ, WR_DATA, DONE
  } state_t;

  state_t                    state;
  logic                      launch_q;
  logic                      start;
  logic                      last;
  logic [HOST_DATA_BITS-1:0] rem;
  logic [HOST_DATA_BITS-1:0] rem_nxt;
  logic [MEM_ADDR_BITS-1:0]  rd_addr;
  logic [MEM_ADDR_BITS-1:0]  wr_addr;
  logic [MEM_ADDR_BITS-1:0]  rd_addr_nxt;
  logic [MEM_ADDR_BITS-1:0]  wr_addr_nxt;
  logic [BW-1:0]             beats;
  logic [IW-1:0]             idx;
  logic [MEM_DATA_BITS-1:0]  beat_buf [MAX_BURST];

  function automatic logic [BW-1:0] burst_of(
    input logic [HOST_DATA_BITS-1:0] r
  );
    if (r >= HOST_DATA_BITS'(MAX_BURST)) return BW'(MAX_BURST);
    return BW'(r);
  endfunction

  function automatic logic [MEM_LEN_BITS-1:0] len_of(
    input logic [BW-1:0] b
  );
    return MEM_LEN_BITS'(b - BW'(1));
  endfunction

  assign start = launch & ~launch_q & (state == IDLE);
  assign last = (BW'(idx) == beats - BW'(1));
  assign rem_nxt = rem - HOST_DATA_BITS'(beats);
  assign rd_addr_nxt = rd_addr + MEM_ADDR_BITS'(beats) * STEP;
  assign wr_addr_nxt = wr_addr + MEM_ADDR_BITS'(beats) * STEP;

  // Run sequencer; every memory-side output is registered here.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      launch_q       <= 1'b0;
      finish         <= 1'b0;
      rem            <= '0;
      rd_addr        <= '0;
      wr_addr        <= '0;
      beats          <= '0;
      idx            <= '0;
      mem_req_valid  <= 1'b0;
      mem_req_opcode <= 1'b0;
      mem_req_len    <= '0;
      mem_req_addr   <= '0;
      mem_rd_ready   <= 1'b0;
      mem_wr_valid   <= 1'b0;
      mem_wr_bits    <= '0;
    end else begin
      launch_q <= launch;
      unique case (state)
        IDLE: begin
          if (start) begin
            rem     <= length;
            rd_addr <= inp_baddr;
            wr_addr <= out_baddr;
            idx     <= '0;
            if (length == '0) begin
              state  <= DONE;
              finish <= 1'b1;
            end else begin
              state          <= RD_REQ;
              beats          <= burst_of(length);
              mem_req_valid  <= 1'b1;
              mem_req_opcode <= 1'b0;
              mem_req_addr   <= inp_baddr;
              mem_req_len    <= len_of(burst_of(length));
            end
          end
        end
        RD_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            mem_rd_ready  <= 1'b1;
            state         <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (mem_rd_valid) begin
            idx <= idx + IW'(1);
            if (last) begin
              idx            <= '0;
              mem_rd_ready   <= 1'b0;
              mem_req_valid  <= 1'b1;
              mem_req_opcode <= 1'b1;
              mem_req_addr   <= wr_addr;
              mem_req_len    <= len_of(beats);
              state          <= WR_REQ;
            end
          end
        end
        WR_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            mem_wr_valid  <= 1'b1;
            mem_wr_bits   <= beat_buf[0] + ADDV;
            state         <= WR_DATA;
          end
        end
        WR_DATA: begin
          if (mem_wr_ready) begin
            if (last) begin
              mem_wr_valid <= 1'b0;
              idx          <= '0;
              rem          <= rem_nxt;
              rd_addr      <= rd_addr_nxt;
              wr_addr      <= wr_addr_nxt;
              if (rem_nxt == '0) begin
                state  <= DONE;
                finish <= 1'b1;
              end else begin
                state          <= RD_REQ;
                beats          <= burst_of(rem_nxt);
                mem_req_valid  <= 1'b1;
                mem_req_opcode <= 1'b0;
                mem_req_addr   <= rd_addr_nxt;
                mem_req_len    <= len_of(burst_of(rem_nxt));
              end
            end else begin
              idx         <= idx + IW'(1);
              mem_wr_bits <= beat_buf[idx + IW'(1)] + ADDV;
            end
          end
        end
        DONE: begin
          finish <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Burst staging buffer; holds data only, so it needs no reset.
  always_ff @(posedge clock) begin
    if (state == RD_DATA && mem_rd_valid) beat_buf[idx] <= mem_rd_bits;
  end

`ifdef VEC_ADD_CYCLE_CNT_EN
  // Run length counter: start cycle counts as 1, frozen in DONE/IDLE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cycles <= '0;
    end else if (start) begin
      cycles <= HOST_DATA_BITS'(1);
    end else if (state != IDLE && state != DONE && cycles != '1) begin
      cycles <= cycles + HOST_DATA_BITS'(1);
    end
  end
`endif

endmodule

// File: tb/tb_vec_add_compute.sv
// tb_vec_add_compute: randomized scoreboard bench with a memory responder
// and a burst-level reference model.
module tb_vec_add_compute;

  localparam logic [63:0] ADD = 64'd1;
  localparam int          MB  = 16;

  typedef struct packed {
    logic        op;
    logic [7:0]  len;
    logic [63:0] addr;
  } req_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        launch;
  logic        finish;
  logic [31:0] length;
  logic [63:0] inp_baddr;
  logic [63:0] out_baddr;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_opcode;
  logic [7:0]  mem_req_len;
  logic [63:0] mem_req_addr;
  logic        mem_rd_valid;
  logic        mem_rd_ready;
  logic [63:0] mem_rd_bits;
  logic        mem_wr_valid;
  logic        mem_wr_ready;
  logic [63:0] mem_wr_bits;
`ifdef VEC_ADD_CYCLE_CNT_EN
  logic [31:0] cycles;
`endif

  always #5 clock = ~clock;

  vec_add_compute dut (
    .clock(clock),
    .reset(reset),
    .launch(launch),
    .finish(finish),
    .length(length),
    .inp_baddr(inp_baddr),
    .out_baddr(out_baddr),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_opcode(mem_req_opcode),
    .mem_req_len(mem_req_len),
    .mem_req_addr(mem_req_addr),
    .mem_rd_valid(mem_rd_valid),
    .mem_rd_ready(mem_rd_ready),
    .mem_rd_bits(mem_rd_bits),
    .mem_wr_valid(mem_wr_valid),
    .mem_wr_ready(mem_wr_ready),
    .mem_wr_bits(mem_wr_bits)
`ifdef VEC_ADD_CYCLE_CNT_EN
    ,
    .cycles(cycles)
`endif
  );

  int checks = 0;
  int failures = 0;
  int fin_count = 0;

  req_t        exp_req[$];
  logic [63:0] exp_wr_data[$];
  logic [63:0] exp_wr_addr[$];
  logic [63:0] mem_in [logic [63:0]];

  int req_delay = 0;
  bit rand_req = 0;
  int wr_mode = 0;
  bit rd_gappy = 0;

  logic [63:0] rd_base, wr_base;
  int rd_left = 0, rd_idx = 0, wr_idx = 0;
  int req_wait = 0;

  task automatic chk(input string name, input logic [95:0] act,
                     input logic [95:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [63:0] mem_get(input logic [63:0] a);
    return mem_in.exists(a) ? mem_in[a] : 64'h0;
  endfunction

  // Reference model: chop the run into bursts, output = input + ADD.
  task automatic expect_run(input logic [31:0] n, input logic [63:0] ia,
                            input logic [63:0] oa);
    int unsigned off, b;
    req_t r;
    off = 0;
    while (off < n) begin
      b = (n - off > MB) ? MB : n - off;
      r.op = 1'b0; r.len = 8'(b - 1); r.addr = ia + 64'(off) * 8;
      exp_req.push_back(r);
      r.op = 1'b1; r.addr = oa + 64'(off) * 8;
      exp_req.push_back(r);
      for (int i = 0; i < int'(b); i++) begin
        exp_wr_addr.push_back(oa + 64'(off + i) * 8);
        exp_wr_data.push_back(mem_get(ia + 64'(off + i) * 8) + ADD);
      end
      off += b;
    end
  endtask

  task automatic fill_rand(input logic [63:0] ia, input int n);
    for (int i = 0; i < n; i++)
      mem_in[ia + 64'(i) * 8] = {$urandom, $urandom};
  endtask

  task automatic flush();
    exp_req.delete();
    exp_wr_data.delete();
    exp_wr_addr.delete();
  endtask

  task automatic apply_reset();
    launch = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    flush();
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Memory responder: drives slave-side inputs just after each edge.
  always @(posedge clock) begin
    #1;
    if (reset) begin
      mem_req_ready = 1'b0;
      mem_rd_valid = 1'b0;
      mem_wr_ready = 1'b0;
      req_wait = 0;
    end else begin
      if (mem_req_valid && !mem_req_ready) begin
        if (req_wait >= req_delay) mem_req_ready = 1'b1;
        else req_wait++;
      end else begin
        mem_req_ready = 1'b0;
        req_wait = 0;
        if (rand_req) req_delay = $urandom_range(0, 3);
      end
      if (mem_rd_ready && rd_left > 0 &&
          (!rd_gappy || $urandom_range(0, 1) == 1)) begin
        mem_rd_valid = 1'b1;
        mem_rd_bits = mem_get(rd_base + 64'(rd_idx) * 8);
      end else begin
        mem_rd_valid = !mem_rd_ready && ($urandom_range(0, 1) == 1);
        mem_rd_bits = {$urandom, $urandom};
      end
      case (wr_mode)
        1: mem_wr_ready = ~mem_wr_ready;
        2: mem_wr_ready = ($urandom_range(0, 3) != 0);
        default: mem_wr_ready = 1'b1;
      endcase
    end
  end

  // Monitor: handshakes seen here complete at the following rising edge.
  logic pend_req = 0, pend_wr = 0, fin_prev = 0;
  req_t prev_req, cur;
  logic [63:0] prev_wr;
  always @(negedge clock) begin
    if (reset) begin
      pend_req = 0;
      pend_wr = 0;
      fin_prev = 0;
      rd_left = 0;
    end else begin
      cur.op = mem_req_opcode;
      cur.len = mem_req_len;
      cur.addr = mem_req_addr;
      if (pend_req) begin
        chk("req_hold_valid", 96'(mem_req_valid), 96'd1);
        chk("req_hold_fields", 96'(cur), 96'(prev_req));
      end
      if (pend_wr) begin
        chk("wr_hold_valid", 96'(mem_wr_valid), 96'd1);
        chk("wr_hold_bits", 96'(mem_wr_bits), 96'(prev_wr));
      end
      if (mem_req_valid && mem_req_ready) begin
        if (exp_req.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL req_unexpected actual=%h required=none", cur);
        end else begin
          chk("req", 96'(cur), 96'(exp_req.pop_front()));
        end
        if (!mem_req_opcode) begin
          rd_base = mem_req_addr;
          rd_left = int'(mem_req_len) + 1;
          rd_idx = 0;
        end else begin
          wr_base = mem_req_addr;
          wr_idx = 0;
        end
      end
      if (mem_rd_valid && mem_rd_ready && rd_left > 0) begin
        rd_idx++;
        rd_left--;
      end
      if (mem_wr_valid && mem_wr_ready) begin
        if (exp_wr_data.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL wr_unexpected actual=%h required=none",
                   mem_wr_bits);
        end else begin
          chk("wr_data", 96'(mem_wr_bits), 96'(exp_wr_data.pop_front()));
          chk("wr_addr", 96'(wr_base + 64'(wr_idx) * 8),
              96'(exp_wr_addr.pop_front()));
        end
        wr_idx++;
      end
      if (finish) begin
        fin_count++;
        chk("finish_width", 96'(fin_prev), 96'd0);
      end
      fin_prev = finish;
      pend_req = mem_req_valid && !mem_req_ready;
      prev_req = cur;
      pend_wr = mem_wr_valid && !mem_wr_ready;
      prev_wr = mem_wr_bits;
    end
  end

  task automatic run(input logic [31:0] n, input logic [63:0] ia,
                     input logic [63:0] oa, input bit mid_change,
                     input bit hold);
    int f0;
    bit done;
    expect_run(n, ia, oa);
    f0 = fin_count;
    @(posedge clock);
    #2;
    length = n;
    inp_baddr = ia;
    out_baddr = oa;
    launch = 1'b1;
    if (mid_change) begin
      repeat (3) @(posedge clock);
      #2;
      length = 32'd4;
      inp_baddr = ~ia;
      out_baddr = 64'h0;
    end
    done = 0;
    for (int c = 0; c < int'(n) * 12 + 300; c++) begin
      @(negedge clock);
      if (fin_count != f0) begin
        done = 1;
        break;
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL run_timeout actual=no_finish required=finish len=%0d",
               n);
      apply_reset();
      return;
    end
    repeat (3) @(posedge clock);
    chk("finish_count", 96'(fin_count - f0), 96'd1);
    chk("req_left", 96'(exp_req.size()), 96'd0);
    chk("wr_left", 96'(exp_wr_data.size()), 96'd0);
    if (hold) begin
      repeat (40) @(posedge clock);
      chk("no_restart", 96'(fin_count - f0), 96'd1);
    end
    #2;
    launch = 1'b0;
    @(posedge clock);
  endtask

  initial begin
    int f0;
    logic [63:0] ia, oa;
    bit seen;
    reset = 1'b1;
    launch = 1'b0;
    length = '0;
    inp_baddr = '0;
    out_baddr = '0;
    mem_req_ready = 1'b0;
    mem_rd_valid = 1'b0;
    mem_rd_bits = '0;
    mem_wr_ready = 1'b0;
    repeat (3) @(posedge clock);
    #2;
    chk("reset_outputs", 96'({mem_req_valid, mem_req_opcode, mem_req_len,
        mem_req_addr, mem_rd_ready, mem_wr_valid, finish}), 96'd0);
    chk("reset_wr_bits", 96'(mem_wr_bits), 96'd0);
`ifdef VEC_ADD_CYCLE_CNT_EN
    chk("reset_cycles", 96'(cycles), 96'd0);
`endif
    @(negedge clock);
    reset = 1'b0;

    // length 0: finish in the cycle after the start edge, no requests
    f0 = fin_count;
    @(posedge clock);
    #2;
    length = 32'd0;
    launch = 1'b1;
    @(negedge clock);
    chk("len0_fin_early", 96'(finish), 96'd0);
    @(posedge clock);
    #2;
    chk("len0_fin_high", 96'(finish), 96'd1);
`ifdef VEC_ADD_CYCLE_CNT_EN
    chk("len0_cycles", 96'(cycles), 96'd1);
`endif
    @(posedge clock);
    #2;
    chk("len0_fin_low", 96'(finish), 96'd0);
    repeat (5) @(posedge clock);
    chk("len0_fin_count", 96'(fin_count - f0), 96'd1);
    #2;
    launch = 1'b0;
    @(posedge clock);

    // length 3 with an all-ones word that wraps to zero
    mem_in[64'h1000] = 64'd5;
    mem_in[64'h1008] = 64'hFFFF_FFFF_FFFF_FFFF;
    mem_in[64'h1010] = 64'd7;
    run(32'd3, 64'h1000, 64'h2000, 0, 0);

    // length 20 spans a full burst plus a tail
    fill_rand(64'h1000, 20);
    run(32'd20, 64'h1000, 64'h2000, 0, 0);

    // stalls: slow request accept, alternating write ready, gappy reads
    req_delay = 5;
    wr_mode = 1;
    rd_gappy = 1;
    fill_rand(64'h3000, 10);
    run(32'd10, 64'h3000, 64'h4000, 0, 0);
    req_delay = 0;
    wr_mode = 0;
    rd_gappy = 0;

    // reset in the middle of the write phase
    fill_rand(64'h5000, 8);
    expect_run(32'd8, 64'h5000, 64'h6000);
    f0 = fin_count;
    @(posedge clock);
    #2;
    length = 32'd8;
    inp_baddr = 64'h5000;
    out_baddr = 64'h6000;
    launch = 1'b1;
    seen = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clock);
      if (mem_wr_valid) begin
        seen = 1;
        break;
      end
    end
    chk("rst_reach_wr", 96'(seen), 96'd1);
    #2;
    reset = 1'b1;
    launch = 1'b0;
    #1;
    chk("rst_async_outputs", 96'({mem_req_valid, mem_req_opcode,
        mem_req_len, mem_req_addr, mem_rd_ready, mem_wr_valid, finish}),
        96'd0);
    chk("rst_async_wr_bits", 96'(mem_wr_bits), 96'd0);
    repeat (2) @(posedge clock);
    flush();
    @(negedge clock);
    reset = 1'b0;
    repeat (10) @(posedge clock);
    chk("rst_no_finish", 96'(fin_count - f0), 96'd0);
    fill_rand(64'h5000, 8);
    run(32'd8, 64'h5000, 64'h6000, 0, 0);

    // launch held high; length changed mid-run
    fill_rand(64'h7000, 6);
    run(32'd6, 64'h7000, 64'h8000, 1, 1);

    // address wrap at the top of the address space
    ia = 64'hFFFF_FFFF_FFFF_FFE0;
    fill_rand(ia, 21);
    run(32'd21, ia, 64'hFFFF_FFFF_FFFF_FF00, 0, 0);

    // randomized runs with random handshakes
    rand_req = 1;
    wr_mode = 2;
    rd_gappy = 1;
    for (int k = 0; k < 8; k++) begin
      int n;
      n = $urandom_range(1, 40);
      ia = {$urandom, $urandom};
      oa = {$urandom, $urandom};
      fill_rand(ia, n);
      run(32'(n), ia, oa, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
